// File: rtl/input_port_scanner.sv
// Synchronises, debounces and edge-detects N input pins, then reports each masked
// level change as a (pin, level) event over valid/ready in round-robin order.
module input_port_scanner #(
   parameter int N_PINS          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int IDX_W           = $clog2(N_PINS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_PINS-1:0] pins_in,
   input  logic [N_PINS-1:0] pin_mask,
   input  logic              evt_ready,
   output logic              evt_valid,
   output logic [IDX_W-1:0]  evt_pin,
   output logic              evt_level,
   output logic [N_PINS-1:0] pin_state,
   output logic              overrun
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PRESENT = 1'b1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PINS - 1);

   logic [N_PINS-1:0] pin_state_q;
   logic [N_PINS-1:0] pin_upd;
   logic [N_PINS-1:0] pin_edge;
   logic [N_PINS-1:0] pending_q, pending_d;
   logic [N_PINS-1:0] eligible;
   logic [N_PINS-1:0] clr;
   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  evt_pin_q, evt_pin_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  sel_idx;
   logic              sel_found;
   logic              load;
   logic              evt_level_q, evt_level_d;
   logic              overrun_q, overrun_d;

   genvar gi;
   generate
      for (gi = 0; gi < N_PINS; gi++) begin : g_pin
         logic [SYNC_STAGES-1:0] sync_q;
         logic [CNT_W-1:0]       cnt_q, cnt_d;
         logic                   differs;

         // Counter tracks consecutive samples that disagree with the accepted level.
         assign differs      = sync_q[SYNC_STAGES-1] ^ pin_state_q[gi];
         assign pin_upd[gi]  = differs && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
         assign cnt_d        = (differs && !pin_upd[gi]) ? cnt_q + 1'b1 : '0;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q <= '0;
               cnt_q  <= '0;
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], pins_in[gi]};
               cnt_q  <= cnt_d;
            end
         end
      end
   endgenerate

   assign pin_edge = pin_upd & pin_mask;
   assign eligible = pending_q & pin_mask;

   // Lowest offset from rr_ptr wins, so scan offsets from the top down.
   always_comb begin
      int p;
      p         = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = N_PINS - 1; k >= 0; k--) begin
         p = (int'(rr_ptr_q) + k) % N_PINS;
         if (eligible[p]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(p);
         end
      end
   end

   always_comb begin
      load = sel_found && ((state_q == ST_IDLE) || evt_ready);
      clr  = '0;
      if (load) clr[sel_idx] = 1'b1;
      // A fresh edge re-arms a pin even while it is being loaded.
      pending_d   = ((pending_q & ~clr) | pin_edge) & pin_mask;
      overrun_d   = |(pin_edge & pending_q & ~clr);
      state_d     = state_q;
      evt_pin_d   = evt_pin_q;
      evt_level_d = evt_level_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         state_d     = ST_PRESENT;
         evt_pin_d   = sel_idx;
         evt_level_d = pin_state_q[sel_idx];
         rr_ptr_d    = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
      end else if ((state_q == ST_PRESENT) && evt_ready) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pin_state_q <= '0;
         pending_q   <= '0;
         state_q     <= ST_IDLE;
         evt_pin_q   <= '0;
         evt_level_q <= 1'b0;
         rr_ptr_q    <= '0;
         overrun_q   <= 1'b0;
      end else begin
         pin_state_q <= pin_state_q ^ pin_upd;
         pending_q   <= pending_d;
         state_q     <= state_d;
         evt_pin_q   <= evt_pin_d;
         evt_level_q <= evt_level_d;
         rr_ptr_q    <= rr_ptr_d;
         overrun_q   <= overrun_d;
      end
   end

   assign evt_valid = (state_q == ST_PRESENT);
   assign evt_pin   = evt_pin_q;
   assign evt_level = evt_level_q;
   assign pin_state = pin_state_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_input_port_scanner.sv
// Directed bench for input_port_scanner: a behavioural reference model checked every
// cycle, plus hand-computed expectations for latency, ordering, overrun and masking.
module tb_input_port_scanner;

   localparam int N = 4;
   localparam int S = 2;
   localparam int D = 4;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] pins_in;
   logic [N-1:0] pin_mask;
   logic         evt_ready;
   logic         evt_valid;
   logic [W-1:0] evt_pin;
   logic         evt_level;
   logic [N-1:0] pin_state;
   logic         overrun;

   input_port_scanner #(
      .N_PINS(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .IDX_W(W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pins_in(pins_in), .pin_mask(pin_mask),
      .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_pin(evt_pin),
      .evt_level(evt_level), .pin_state(pin_state), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: level accepted once D consecutive synced samples disagree.
   logic [N-1:0] hist[$];
   bit   [N-1:0] m_state, m_pending;
   bit           m_valid, m_level, m_ovr;
   int           m_pin, m_rr;
   bit   [N-1:0] m_upd, m_edg, m_elig, m_clr, smp;
   bit           m_load, all_diff;
   int           k_now, sel;

   function automatic logic [N-1:0] synced(input int m);
      int idx;
      idx = m - S;
      if (idx >= 1) return hist[idx-1];
      return '0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist.delete();
         m_state = '0; m_pending = '0; m_valid = 0; m_level = 0;
         m_ovr = 0; m_pin = 0; m_rr = 0;
      end else begin
         hist.push_back(pins_in);
         k_now = hist.size();
         m_upd = '0;
         for (int i = 0; i < N; i++) begin
            all_diff = 1;
            for (int j = 0; j < D; j++) begin
               smp = synced(k_now - j);
               if (smp[i] == m_state[i]) all_diff = 0;
            end
            m_upd[i] = all_diff;
         end
         m_edg  = m_upd & pin_mask;
         m_elig = m_pending & pin_mask;
         m_load = (m_elig != 0) && (!m_valid || evt_ready);
         m_clr  = '0;
         sel    = -1;
         if (m_load) begin
            for (int off = 0; off < N; off++)
               if (sel < 0 && m_elig[(m_rr + off) % N]) sel = (m_rr + off) % N;
            m_clr[sel] = 1;
         end
         m_ovr     = |(m_edg & m_pending & ~m_clr);
         m_pending = ((m_pending & ~m_clr) | m_edg) & pin_mask;
         if (m_load) begin
            m_valid = 1;
            m_pin   = sel;
            m_level = m_state[sel];
            m_rr    = (sel + 1) % N;
         end else if (m_valid && evt_ready) begin
            m_valid = 0;
         end
         m_state = m_state ^ m_upd;
      end
   end

   // Compare process plus a log of accepted events, encoded as hex digits pin*2+level+1.
   int acc_code   = 0;
   int ovr_cnt    = 0;
   bit valid_seen = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("pin_state", pin_state, m_state);
         chk("evt_valid", evt_valid, m_valid);
         if (m_valid) begin
            chk("evt_pin", evt_pin, m_pin);
            chk("evt_level", evt_level, m_level);
         end
         chk("overrun", overrun, m_ovr);
         if (evt_valid) valid_seen = 1;
         if (overrun) ovr_cnt++;
         if (evt_valid && evt_ready) begin
            acc_code = acc_code * 16 + int'(evt_pin) * 2 + int'(evt_level) + 1;
            $display("txn pin=%0d level=%0d t=%0t", evt_pin, evt_level, $time);
         end
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; pins_in = '0; pin_mask = 4'b1111; evt_ready = 1'b1;
      wait_edges(3);
      chk("reset_valid", evt_valid, 0);
      chk("reset_pin", evt_pin, 0);
      chk("reset_level", evt_level, 0);
      chk("reset_state", pin_state, 0);
      chk("reset_overrun", overrun, 0);
      rst_n = 1'b1;
      wait_edges(2);

      // Glitch shorter than the debounce window
      valid_seen = 0;
      pins_in = 4'b0100;
      wait_edges(3);
      pins_in = 4'b0000;
      wait_edges(15);
      chk("glitch_state", pin_state, 4'b0000);
      chk("glitch_no_valid", valid_seen, 0);

      // Clean rise on pin 1: valid at edge 7
      acc_code = 0;
      pins_in = 4'b0010;
      wait_edges(6);
      chk("rise_state_e6", pin_state, 4'b0010);
      chk("rise_valid_e6", evt_valid, 0);
      wait_edges(1);
      chk("rise_valid_e7", evt_valid, 1);
      chk("rise_pin_e7", evt_pin, 1);
      chk("rise_level_e7", evt_level, 1);
      wait_edges(1);
      chk("rise_valid_e8", evt_valid, 0);
      chk("rise_acc", acc_code, 32'h4);

      // Fresh reset so the round-robin pointer starts at 0
      pins_in = '0;
      rst_n = 1'b0;
      wait_edges(2);
      rst_n = 1'b1;
      wait_edges(2);

      acc_code = 0;
      pins_in = 4'b1011;
      wait_edges(6);
      chk("rr_valid_e6", evt_valid, 0);
      wait_edges(1);
      chk("rr_pin_e7", evt_pin, 0);
      wait_edges(4);
      chk("rr_order_rise", acc_code, 32'h248);
      acc_code = 0;
      pins_in = 4'b0010;
      wait_edges(12);
      chk("rr_order_fall", acc_code, 32'h17);

      // Backpressure with a merged second edge on pin 3
      evt_ready = 1'b0;
      ovr_cnt = 0;
      acc_code = 0;
      pins_in = 4'b1010;
      wait_edges(7);
      chk("bp_valid", evt_valid, 1);
      chk("bp_pin", evt_pin, 3);
      chk("bp_level", evt_level, 1);
      pins_in = 4'b0010;
      wait_edges(8);
      pins_in = 4'b1010;
      wait_edges(8);
      chk("bp_overrun_count", ovr_cnt, 1);
      chk("bp_pin_held", evt_pin, 3);
      chk("bp_level_held", evt_level, 1);
      evt_ready = 1'b1;
      wait_edges(4);
      chk("bp_acc", acc_code, 32'h88);

      // Masked pin changes level without producing an event
      acc_code = 0;
      pin_mask = 4'b1011;
      pins_in = 4'b1110;
      wait_edges(10);
      chk("mask_state", pin_state, 4'b1110);
      chk("mask_no_evt", acc_code, 0);
      pin_mask = 4'b1111;
      wait_edges(10);
      chk("unmask_no_evt", acc_code, 0);
      pins_in = 4'b1010;
      wait_edges(10);
      chk("mask_fall_evt", acc_code, 32'h5);

      // Asynchronous reset while an event is presented
      evt_ready = 1'b0;
      pins_in = 4'b1111;
      for (int c = 0; c < 30 && !evt_valid; c++) wait_edges(1);
      chk("pre_reset_valid", evt_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", evt_valid, 0);
      chk("async_pin", evt_pin, 0);
      chk("async_level", evt_level, 0);
      chk("async_state", pin_state, 0);
      chk("async_overrun", overrun, 0);
      wait_edges(3);
      evt_ready = 1'b1;
      acc_code = 0;
      rst_n = 1'b1;
      wait_edges(6);
      chk("post_reset_valid_e6", evt_valid, 0);
      wait_edges(1);
      chk("post_reset_valid_e7", evt_valid, 1);
      chk("post_reset_pin_e7", evt_pin, 0);
      chk("post_reset_level_e7", evt_level, 1);
      wait_edges(5);
      chk("post_reset_acc", acc_code, 32'h2468);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
